// File: rtl/alu_issue.sv
// alu_issue: issue/writeback front end for the 64-bit integer ALU.
// Accepts one RV64I OP/OP-IMM instruction per handshake. Operands come from
// an internal 32x64 register file. The ALU's registered result is written
// back one cycle after issue. Throughput is one instruction every three cycles.
module alu_issue (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    output logic        alu_imm,
    output logic [63:0] alu_op1,
    output logic [63:0] alu_op2,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    input  logic [63:0] alu_res,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_raddr,
    output logic [63:0] dbg_rdata
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] inst_q_reg;
    logic        wb_valid_reg;
    logic [4:0]  wb_rd_reg;
    logic [63:0] wb_data_reg;

    // Entry 0 is never written, so it always reads as zero.
    logic [63:0] regs_reg [32];

    // Decode fields of the latched instruction.
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    logic       is_op;
    logic       is_op_imm;
    logic       legal;
    logic       rf_we;

    assign opcode    = inst_q_reg[6:0];
    assign rd        = inst_q_reg[11:7];
    assign funct3    = inst_q_reg[14:12];
    assign rs1       = inst_q_reg[19:15];
    assign rs2       = inst_q_reg[24:20];
    assign funct7    = inst_q_reg[31:25];
    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);

    // Legality check: only the ALU's implemented ops, with well-formed funct7/shamt.
    always_comb begin
        legal = 1'b0;
        if (funct3 == 3'b110 || funct3 == 3'b111) begin
            legal = 1'b0;
        end else if (is_op) begin
            legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (is_op_imm) begin
            case (funct3)
                3'b001:  legal = (inst_q_reg[31:26] == 6'b000000);
                3'b101:  legal = (inst_q_reg[31:26] == 6'b000000) ||
                                 (inst_q_reg[31:26] == 6'b010000);
                default: legal = 1'b1;
            endcase
        end
    end

    // ALU operand/function drive, only while in ISSUE; zero otherwise.
    always_comb begin
        alu_imm    = 1'b0;
        alu_op1    = '0;
        alu_op2    = '0;
        alu_funct3 = '0;
        alu_funct7 = '0;
        if (state_reg == S_ISSUE) begin
            alu_op1    = regs_reg[rs1];
            alu_funct3 = funct3;
            if (is_op_imm) begin
                alu_imm    = 1'b1;
                alu_op2    = {{52{inst_q_reg[31]}}, inst_q_reg[31:20]};
                // Bit 25 is shamt[5] for 64-bit shifts; mask it so SRAI still
                // presents a clean 0100000 to the ALU's funct7 match.
                alu_funct7 = {inst_q_reg[31:26], 1'b0};
            end else begin
                alu_op2    = regs_reg[rs2];
                alu_funct7 = funct7;
            end
        end
    end

    assign inst_ready = (state_reg == S_IDLE);
    assign illegal    = (state_reg == S_ISSUE) && !legal;
    assign wb_valid   = wb_valid_reg;
    assign wb_rd      = wb_rd_reg;
    // alu_res is live only during WB; afterwards the captured copy is held.
    assign wb_data    = wb_valid_reg ? alu_res : wb_data_reg;
    assign dbg_rdata  = regs_reg[dbg_raddr];
    assign rf_we      = (state_reg == S_WB) && (wb_rd_reg != 5'd0);

    // Issue/writeback sequencer with its registered writeback outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= S_IDLE;
            inst_q_reg   <= '0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (inst_valid) begin
                        inst_q_reg <= inst;
                        state_reg  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (legal) begin
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= rd;
                        state_reg    <= S_WB;
                    end else begin
                        state_reg    <= S_IDLE;
                    end
                end
                S_WB: begin
                    wb_valid_reg <= 1'b0;
                    wb_data_reg  <= alu_res;
                    state_reg    <= S_IDLE;
                end
                default: begin
                    wb_valid_reg <= 1'b0;
                    state_reg    <= S_IDLE;
                end
            endcase
        end
    end

    // Register file: cleared on reset, written with the ALU result at the end of WB.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (rf_we) begin
            regs_reg[wb_rd_reg] <= alu_res;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: table-driven instruction vectors plus hand-written
// sequences for busy-ignore and mid-operation reset. A small registered ALU
// model closes the loop from alu_* outputs to alu_res.
module tb_alu_issue;

    logic        CLK;
    logic        RST_N;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        alu_imm;
    logic [63:0] alu_op1;
    logic [63:0] alu_op2;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [63:0] alu_res;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_raddr;
    logic [63:0] dbg_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    alu_issue dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .alu_imm    (alu_imm),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_res    (alu_res),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .illegal    (illegal),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU (the block's consumer), one-cycle registered result.
    function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic imm);
        case (f3)
            3'b000:  return (!imm && f7[5]) ? a - b : a + b;
            3'b001:  return a << b[5:0];
            3'b010:  return {63'd0, $signed(a) < $signed(b)};
            3'b011:  return {63'd0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return f7[5] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
            default: return 64'd0;
        endcase
    endfunction

    initial alu_res = '0;
    always @(posedge CLK) alu_res <= alu_model(alu_op1, alu_op2, alu_funct3, alu_funct7, alu_imm);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        bit          legal;
        logic [63:0] data;
        logic [6:0]  f7;
        bit          imm;
    } vec_t;

    vec_t        vecs[13];
    logic [63:0] mreg[32];

    // Offer an instruction from a negedge; returns at the negedge inside ISSUE.
    task automatic issue(input logic [31:0] w);
        int n = 0;
        while (!inst_ready && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_before_issue", {63'd0, inst_ready}, 64'd1);
        inst       = w;
        inst_valid = 1'b1;
        @(negedge CLK);
        inst_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 1'b1, 64'd5,                  7'b0000000, 1'b1}; // addi x1,x0,5
        vecs[1]  = '{32'hFFD00113, 1'b1, 64'hFFFFFFFFFFFFFFFD,   7'b1111110, 1'b1}; // addi x2,x0,-3
        vecs[2]  = '{32'h402081B3, 1'b1, 64'd8,                  7'b0100000, 1'b0}; // sub x3,x1,x2
        vecs[3]  = '{32'h40115213, 1'b1, 64'hFFFFFFFFFFFFFFFE,   7'b0100000, 1'b1}; // srai x4,x2,1
        vecs[4]  = '{32'h03C15293, 1'b1, 64'h000000000000000F,   7'b0000000, 1'b1}; // srli x5,x2,60
        vecs[5]  = '{32'h0020E0B3, 1'b0, 64'd0,                  7'b0000000, 1'b0}; // or (illegal)
        vecs[6]  = '{32'h00700013, 1'b1, 64'd7,                  7'b0000000, 1'b1}; // addi x0,x0,7
        vecs[7]  = '{32'h001123B3, 1'b1, 64'd1,                  7'b0000000, 1'b0}; // slt x7,x2,x1
        vecs[8]  = '{32'h00113433, 1'b1, 64'd0,                  7'b0000000, 1'b0}; // sltu x8,x2,x1
        vecs[9]  = '{32'h04009493, 1'b0, 64'd0,                  7'b0000000, 1'b1}; // slli bad shamt
        vecs[10] = '{32'h00309493, 1'b1, 64'd40,                 7'b0000000, 1'b1}; // slli x9,x1,3
        vecs[11] = '{32'h4020C0B3, 1'b0, 64'd0,                  7'b0000000, 1'b0}; // xor w/ funct7 0100000
        vecs[12] = '{32'h0020C533, 1'b1, 64'hFFFFFFFFFFFFFFF8,   7'b0000000, 1'b0}; // xor x10,x1,x2
        for (int i = 0; i < 32; i++) mreg[i] = '0;

        RST_N      = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        dbg_raddr  = '0;
        repeat (2) @(negedge CLK);

        chk("rst_inst_ready", {63'd0, inst_ready}, 64'd1);
        chk("rst_wb_valid",   {63'd0, wb_valid},   64'd0);
        chk("rst_wb_rd",      {59'd0, wb_rd},      64'd0);
        chk("rst_wb_data",    wb_data,             64'd0);
        chk("rst_illegal",    {63'd0, illegal},    64'd0);
        chk("rst_alu_op1",    alu_op1,             64'd0);
        chk("rst_alu_op2",    alu_op2,             64'd0);
        chk("rst_alu_f7",     {57'd0, alu_funct7}, 64'd0);
        $display("reset: inst_ready=%0b wb_valid=%0b illegal=%0b", inst_ready, wb_valid, illegal);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 13; v++) begin
            logic [4:0] rd;
            logic [4:0] rs1;
            rd  = vecs[v].word[11:7];
            rs1 = vecs[v].word[19:15];
            issue(vecs[v].word);
            // T+1: ISSUE
            chk("issue_ready", {63'd0, inst_ready}, 64'd0);
            chk("issue_illegal", {63'd0, illegal}, {63'd0, !vecs[v].legal});
            chk("issue_wb_valid", {63'd0, wb_valid}, 64'd0);
            if (vecs[v].legal) begin
                chk("issue_funct7", {57'd0, alu_funct7}, {57'd0, vecs[v].f7});
                chk("issue_imm",    {63'd0, alu_imm},    {63'd0, vecs[v].imm});
                chk("issue_op1",    alu_op1,             mreg[rs1]);
                chk("issue_funct3", {61'd0, alu_funct3}, {61'd0, vecs[v].word[14:12]});
            end
            @(negedge CLK);
            // T+2: WB or back to IDLE
            if (vecs[v].legal) begin
                chk("wb_valid", {63'd0, wb_valid}, 64'd1);
                chk("wb_rd",    {59'd0, wb_rd},    {59'd0, rd});
                chk("wb_data",  wb_data,           vecs[v].data);
                if (rd != 5'd0) mreg[rd] = vecs[v].data;
            end else begin
                chk("illegal_no_wb",   {63'd0, wb_valid},   64'd0);
                chk("illegal_pulse",   {63'd0, illegal},    64'd0);
                chk("illegal_ready",   {63'd0, inst_ready}, 64'd1);
            end
            @(negedge CLK);
            // T+3: IDLE, outputs settled
            chk("idle_ready",    {63'd0, inst_ready}, 64'd1);
            chk("idle_wb_valid", {63'd0, wb_valid},   64'd0);
            if (vecs[v].legal) chk("wb_data_hold", wb_data, vecs[v].data);
            dbg_raddr = rd;
            #1;
            chk("dbg_rd", dbg_rdata, mreg[rd]);
            $display("inst %h legal=%0b rd=x%0d wb_data=%h dbg=%h", vecs[v].word,
                     vecs[v].legal, rd, wb_data, dbg_rdata);
        end

        // inst_valid while busy is ignored, not buffered.
        issue(32'h00100593);                 // addi x11,x0,1
        inst       = 32'h00200613;           // addi x12,x0,2 offered while busy
        inst_valid = 1'b1;
        @(negedge CLK);
        chk("busy_ready_wb", {63'd0, inst_ready}, 64'd0);
        chk("busy_wb_rd",    {59'd0, wb_rd},      64'd11);
        chk("busy_wb_data",  wb_data,             64'd1);
        mreg[11]   = 64'd1;
        inst_valid = 1'b0;
        @(negedge CLK);
        chk("busy_idle_ready", {63'd0, inst_ready}, 64'd1);
        @(negedge CLK);
        chk("busy_not_taken", {63'd0, inst_ready}, 64'd1);
        chk("busy_no_wb",     {63'd0, wb_valid},   64'd0);
        dbg_raddr = 5'd12;
        #1;
        chk("busy_x12", dbg_rdata, 64'd0);
        dbg_raddr = 5'd11;
        #1;
        chk("busy_x11", dbg_rdata, 64'd1);
        $display("busy-ignore: x11=%h inst_ready=%0b", dbg_rdata, inst_ready);

        // Reset asserted during ISSUE aborts the operation.
        @(negedge CLK);
        issue(32'h00900313);                 // addi x6,x0,9
        RST_N = 1'b0;
        #1;
        chk("arst_ready",    {63'd0, inst_ready}, 64'd1);
        chk("arst_illegal",  {63'd0, illegal},    64'd0);
        chk("arst_wb_valid", {63'd0, wb_valid},   64'd0);
        chk("arst_wb_rd",    {59'd0, wb_rd},      64'd0);
        chk("arst_wb_data",  wb_data,             64'd0);
        chk("arst_op1",      alu_op1,             64'd0);
        chk("arst_op2",      alu_op2,             64'd0);
        chk("arst_imm",      {63'd0, alu_imm},    64'd0);
        for (int r = 1; r <= 6; r++) begin
            dbg_raddr = 5'(r);
            #1;
            chk("arst_reg", dbg_rdata, 64'd0);
        end
        @(negedge CLK);
        chk("arst_hold_wb", {63'd0, wb_valid}, 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("arst_after_wb", {63'd0, wb_valid}, 64'd0);
        dbg_raddr = 5'd6;
        #1;
        chk("arst_x6", dbg_rdata, 64'd0);
        $display("mid-op reset: wb_valid=%0b x6=%h", wb_valid, dbg_rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/writeback front end for the 64-bit integer ALU: accepts one RV64I OP or OP-IMM instruction per handshake, reads operands from an internal 32×64 register file, and drives the ALU operand/function inputs. It captures the ALU's registered result one cycle later and writes it back to the register file. It sits between the fetch/decode stage and the ALU, forming the producer and consumer end of the ALU interface.

## Interface
- Parameters: none; XLEN fixed at 64, 32 architectural registers.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- inst_valid  in  1  instruction offered.
- inst  in  32  instruction word.
- inst_ready  out  1  block can accept; high only in IDLE.
- alu_imm  out  1  to ALU `imm`.
- alu_op1  out  64  to ALU `op1`.
- alu_op2  out  64  to ALU `op2`.
- alu_funct3  out  3  to ALU `funct3`.
- alu_funct7  out  7  to ALU `funct7`.
- alu_res  in  64  from ALU `res`; registered, valid the cycle after issue.
- wb_valid  out  1  one-cycle pulse; writeback performed.
- wb_rd  out  5  destination register.
- wb_data  out  64  written value.
- illegal  out  1  one-cycle pulse; accepted instruction dropped.
- dbg_raddr  in  5  debug read address.
- dbg_rdata  out  64  combinational register-file read; x0 reads 0.

## Operation
- FSM states: IDLE, ISSUE, WB.
  - IDLE → ISSUE on inst_valid & inst_ready; inst latched into inst_q.
  - ISSUE → WB if legal; ISSUE → IDLE with illegal=1 if not.
  - WB → IDLE unconditionally.
- Decode is performed from inst_q:
  - opcode 0010011 = OP-IMM; 0110011 = OP.
  - rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20].
- alu_op1 = R[rs1].
- OP: alu_op2 = R[rs2], alu_imm = 0, alu_funct7 = inst_q[31:25].
- OP-IMM: alu_op2 = sign-extended inst_q[31:20], alu_imm = 1.
  - alu_funct7 = {inst_q[31:26], 1'b0}, so that SRAI's shamt[5] does not corrupt the funct7 match.
  - The ALU shifts by op2[5:0].
- alu_funct3 = funct3.
- Illegal conditions (no ALU result used, no writeback):
  - opcode not OP or OP-IMM.
  - funct3 110 or 111 (the ALU does not implement OR/AND).
  - OP with funct7 not 0000000, or 0100000 with funct3 not in {000, 101}.
  - OP-IMM funct3 001 with inst_q[31:26] ≠ 000000.
  - OP-IMM funct3 101 with inst_q[31:26] not in {000000, 010000}.
- Writeback in WB:
  - wb_data = alu_res, wb_rd = rd.
  - R[rd] is written at the end of WB if rd ≠ 0.
  - rd = 0 still pulses wb_valid; x0 stays 0.
- Outside ISSUE, all alu_* outputs are driven to 0.

## Timing
- Reset: state IDLE, inst_ready = 1, wb_valid = 0, wb_rd = 0, wb_data = 0, illegal = 0, all alu_* = 0, all registers 0.
- Accept at cycle T:
  - ALU inputs are valid during T+1 (ISSUE).
  - alu_res and wb_valid are valid in T+2.
  - The next accept is possible at T+3.
- Throughput is 1 instruction per 3 cycles. No hazards: a write completes before the next read.
- Illegal instruction: illegal pulses in T+1; inst_ready returns high in T+2.
- inst_valid while inst_ready = 0 is ignored, with no buffering. The source must hold inst.
- Reset asserted mid-operation aborts immediately: no wb_valid, no illegal, register file cleared.
- wb_data and wb_rd hold their last values after WB. wb_valid and illegal are single-cycle pulses.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) → wb_valid at T+2, wb_rd = 1, wb_data = 5; dbg x1 = 5.
- `addi x2,x0,-3` (0xFFD00113) → x2 = 0xFFFFFFFFFFFFFFFD; then `sub x3,x1,x2` (0x402081B3) → alu_funct7 = 0100000 in ISSUE, x3 = 8.
- `srai x4,x2,1` (0x40115213) → alu_funct7 = 0100000, x4 = 0xFFFFFFFFFFFFFFFE; `srli x5,x2,60` (0x03C15293) → x5 = 0xF.
- `or x1,x1,x2` (0x0020E0B3) → illegal pulse at T+1, no wb_valid, x1 still 5; inst_ready high at T+2.
- `addi x0,x0,7` (0x00700013) → wb_valid, wb_rd = 0, wb_data = 7; dbg x0 = 0.
- Deassert RST_N during ISSUE of `addi x6,x0,9` → no wb_valid, all outputs at reset values, x1..x5 = 0.
